// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save pair to binary, CHUNK bits per cycle.
// Ripple carry between chunks is held in a flop to keep the critical path short.
module csa_resolver #(
  parameter int N     = 8,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_sum,
  input  logic [N-1:0]   in_carry,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N+1:0]   out_result,
  output logic           busy
);

  localparam int W      = N + 2;
  localparam int PASSES = (W + CHUNK - 1) / CHUNK;
  localparam int P      = PASSES * CHUNK;
  localparam int CW     = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [P-1:0]   a_reg;
  logic [P-1:0]   b_reg;
  logic [P-1:0]   res_reg;
  logic           carry;
  logic [CW-1:0]  pass_cnt;
  logic [31:0]    base;
  logic [CHUNK:0] slice;
  logic           unused_bits;

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_result = res_reg[W-1:0];

  // Bits above W are provably zero; they exist only to pad the last chunk.
  assign unused_bits = ^res_reg;

  // Current chunk sum: A slice + B slice + ripple carry from previous pass.
  assign base  = 32'(pass_cnt) * 32'(CHUNK);
  assign slice = {1'b0, a_reg[base +: CHUNK]}
               + {1'b0, b_reg[base +: CHUNK]}
               + {{CHUNK{1'b0}}, carry};

  // Control FSM plus operand, carry and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry     <= 1'b0;
      pass_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= P'(in_sum);
            b_reg    <= P'({in_carry, 1'b0});
            carry    <= 1'b0;
            pass_cnt <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          res_reg[base +: CHUNK] <= slice[CHUNK-1:0];
          carry <= slice[CHUNK];
          if (pass_cnt == CW'(PASSES - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            pass_cnt <= pass_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: randomized and directed checks of csa_resolver
// against an arithmetic model (sum + 2*carry).
module tb_csa_resolver;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // Default configuration: N=8, CHUNK=4 -> W=10, 3 passes.
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_sum = '0;
  logic [7:0] in_carry = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] out_result;
  logic       busy;

  // Small configuration: N=1, CHUNK=1 -> W=3, 3 passes.
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic [0:0] in_sum1 = '0;
  logic [0:0] in_carry1 = '0;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [2:0] out_result1;
  logic       busy1;

  int checks = 0;
  int errors = 0;

  csa_resolver #(.N(8), .CHUNK(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
  );

  csa_resolver #(.N(1), .CHUNK(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_sum(in_sum1), .in_carry(in_carry1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_result(out_result1), .busy(busy1)
  );

  // Offer one pair to dut and wait for out_valid; lat counts edges after accept.
  task automatic op0(input logic [7:0] s, input logic [7:0] c,
                     output logic [9:0] res, output int lat);
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_result;
  endtask

  task automatic op1(input logic s, input logic c,
                     output logic [2:0] res, output int lat);
    in_valid1 = 1'b1;
    in_sum1   = s;
    in_carry1 = c;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = out_result1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_result !== 10'd0) begin
      errors++;
      $display("FAIL reset_out_result got %0d want 0", out_result);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_max();
    logic [9:0] r;
    int lat;
    out_ready = 1'b1;
    op0(8'hFF, 8'hFF, r, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("FAIL max_latency got %0d want 3", lat);
    end
    checks++;
    if (r !== 10'h2FD) begin
      errors++;
      $display("FAIL max_result got %0d want 765", r);
    end
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL max_done_flags got rdy=%b busy=%b want 0/1",
               in_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL max_return_idle got rdy=%b ov=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_boundary();
    logic [9:0] r;
    int lat;
    op0(8'h0F, 8'h01, r, lat);
    @(negedge clk);
    checks++;
    if (r !== 10'd17) begin
      errors++;
      $display("FAIL boundary_17 got %0d want 17", r);
    end
    op0(8'h00, 8'h00, r, lat);
    @(negedge clk);
    checks++;
    if (r !== 10'd0 || lat != 3) begin
      errors++;
      $display("FAIL boundary_zero got %0d lat %0d want 0 lat 3", r, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] r;
    logic [9:0] held;
    int lat;
    int bad;
    out_ready = 1'b0;
    op0(8'h12, 8'h34, r, lat);
    checks++;
    if (r !== 10'd122) begin
      errors++;
      $display("FAIL bp_first got %0d want 122", r);
    end
    held = r;
    bad = 0;
    in_valid = 1'b1;
    in_sum   = 8'hA5;
    in_carry = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_result !== held || in_ready !== 1'b0 || out_valid !== 1'b1)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold got %0d bad cycles res=%0d want 0 res=%0d",
               bad, out_result, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b ov=%b want 1/0",
               in_ready, out_valid);
    end
    op0(8'hA5, 8'h3C, r, lat);
    @(negedge clk);
    checks++;
    if (r !== 10'd285 || lat != 3) begin
      errors++;
      $display("FAIL bp_second got %0d lat %0d want 285 lat 3", r, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] r;
    int lat;
    int pulses;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_sum   = 8'hFF;
    in_carry = 8'hFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle got busy=%b rdy=%b ov=%b want 0/1/0",
               busy, in_ready, out_valid);
    end
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrst_no_pulse got %0d pulses want 0", pulses);
    end
    op0(8'h80, 8'h40, r, lat);
    @(negedge clk);
    checks++;
    if (r !== 10'd256) begin
      errors++;
      $display("FAIL midrst_next got %0d want 256", r);
    end
  endtask

  task automatic test_random();
    logic [9:0] r;
    logic [7:0] s;
    logic [7:0] c;
    int exp;
    int lat;
    int bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      s = 8'($urandom);
      c = 8'($urandom);
      exp = int'(s) + 2 * int'(c);
      if (exp >= 1024) bad++;
      out_ready = 1'b0;
      op0(s, c, r, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      if (int'(r) != exp || lat != 3) begin
        bad++;
        $display("FAIL rand_op%0d got %0d lat %0d want %0d lat 3",
                 i, r, lat, exp);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rand_summary got %0d bad ops want 0", bad);
    end
  endtask

  task automatic test_small();
    logic [2:0] r;
    int lat;
    int a;
    int b;
    int c;
    for (int v = 0; v < 8; v++) begin
      a = (v >> 2) & 1;
      b = (v >> 1) & 1;
      c = v & 1;
      op1(1'((a ^ b ^ c) & 1), 1'((a & b) | (a & c) | (b & c)), r, lat);
      @(negedge clk);
      checks++;
      if (int'(r) != a + b + c || lat != 3) begin
        errors++;
        $display("FAIL small_abc%0d%0d%0d got %0d lat %0d want %0d lat 3",
                 a, b, c, r, lat, a + b + c);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_max();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
